sync_fifo: RTL and testbench

Single-clock synchronous FIFO that buffers `WIDTH`-bit words between a producer and a consumer in the same clock domain. It combines four functions:
- write-enable gating that blocks writes while full;
- read-enable gating that blocks reads while empty;
- a dual-pointer storage array;
- full/empty flag generation.

Its storage core is reused wherever a small elastic buffer is required.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 48 ++++
 rtl/sync_fifo.sv | 46 ++++
 tb/tb_sync_fifo.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
// Pointers carry one extra wrap bit above the storage index.
package sync_fifo_pkg;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int UP_BIT = 6;

  typedef logic [UP_BIT-1:0] ptr_t;
  typedef logic [WIDTH-1:0]  data_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-pointer storage core: memory array, write/read pointers and registered read data.
// Enables arrive already gated by the flag logic, so this block never checks occupancy.
module sync_fifo_mem #(
  parameter int WIDTH  = sync_fifo_pkg::WIDTH,
  parameter int DEPTH  = sync_fifo_pkg::DEPTH,
  parameter int UP_BIT = sync_fifo_pkg::UP_BIT
) (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              wen_ok,
  input  logic              ren_ok,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_data,
  output logic [UP_BIT-1:0] wp,
  output logic [UP_BIT-1:0] rp
);

  localparam logic [UP_BIT-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only pointers and o_data are cleared,
  // which keeps the array mappable to plain RAM and is all that empty state needs.
  always_ff @(posedge i_clk) begin
    if (wen_ok && i_rest) begin
      mem[wp[UP_BIT-2:0]] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rest) begin
      wp     <= '0;
      rp     <= '0;
      o_data <= '0;
    end else begin
      if (wen_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (ren_ok) begin
        o_data <= mem[rp[UP_BIT-2:0]];
        rp     <= rp + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO top: enable gating and full/empty flags around the storage core.
// Flags are decoded from the registered pointers, so they change only after a clock edge.
module sync_fifo #(
  parameter int WIDTH  = sync_fifo_pkg::WIDTH,
  parameter int DEPTH  = sync_fifo_pkg::DEPTH,
  parameter int UP_BIT = sync_fifo_pkg::UP_BIT
) (
  input  logic             i_clk,
  input  logic             i_rest,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wen,
  input  logic             i_ren,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [UP_BIT-1:0] wp;
  logic [UP_BIT-1:0] rp;
  logic              wen_ok;
  logic              ren_ok;

  // Equal index with differing wrap bits means the writer is a full lap ahead.
  assign o_empty = (wp == rp);
  assign o_full  = (wp[UP_BIT-1] != rp[UP_BIT-1]) &&
                   (wp[UP_BIT-2:0] == rp[UP_BIT-2:0]);

  assign wen_ok = i_wen & ~o_full;
  assign ren_ok = i_ren & ~o_empty;

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .UP_BIT (UP_BIT)
  ) u_mem (
    .i_clk  (i_clk),
    .i_rest (i_rest),
    .wen_ok (wen_ok),
    .ren_ok (ren_ok),
    .i_data (i_data),
    .o_data (o_data),
    .wp     (wp),
    .rp     (rp)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based model pushes expected read data,
// and a separate monitor compares o_data and the flags after every clock edge.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             i_clk = 1'b0;
  logic             i_rest;
  logic [WIDTH-1:0] i_data;
  logic             i_wen;
  logic             i_ren;
  logic [WIDTH-1:0] o_data;
  logic             o_full;
  logic             o_empty;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q   [$];
  bit               rd_evt;
  bit               rst_evt;
  logic [WIDTH-1:0] last_data;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .UP_BIT(6)) dut (
    .i_clk   (i_clk),
    .i_rest  (i_rest),
    .i_data  (i_data),
    .i_wen   (i_wen),
    .i_ren   (i_ren),
    .o_data  (o_data),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a FIFO is just a bounded queue; reads hand their word to the scoreboard.
  always @(posedge i_clk) begin
    rd_evt  = 1'b0;
    rst_evt = 1'b0;
    if (!i_rest) begin
      model_q.delete();
      exp_q.delete();
      rst_evt = 1'b1;
    end else begin
      bit do_rd, do_wr;
      do_rd = i_ren && (model_q.size() > 0);
      do_wr = i_wen && (model_q.size() < DEPTH);
      if (do_rd) begin
        exp_q.push_back(model_q.pop_front());
        rd_evt = 1'b1;
      end
      if (do_wr) model_q.push_back(i_data);
    end
  end

  // Monitor: samples just after each edge.
  always @(posedge i_clk) begin
    #1;
    if (rst_evt) last_data = '0;
    if (rd_evt) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: read event with no expected word at %0t", $time);
      end else begin
        last_data = exp_q.pop_front();
      end
    end
    check("o_data",  {24'd0, o_data}, {24'd0, last_data});
    check("o_empty", {31'd0, o_empty}, {31'd0, model_q.size() == 0});
    check("o_full",  {31'd0, o_full},  {31'd0, model_q.size() == DEPTH});
  end

  task automatic cyc(input logic rst, input logic wen, input logic ren, input logic [WIDTH-1:0] d);
    i_rest = rst;
    i_wen  = wen;
    i_ren  = ren;
    i_data = d;
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    cyc(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    last_data = '0;
    // Reset held with both enables high.
    cyc(1'b0, 1'b1, 1'b1, 8'h77);
    cyc(1'b0, 1'b1, 1'b1, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // Fill, attempt write while full, drain plus one extra read.
    for (int i = 1; i <= DEPTH; i++) wr(8'(i));
    wr(8'hFF);
    for (int i = 0; i <= DEPTH; i++) rd();

    // Wrap-around: offset pointers, then fill across the index wrap.
    for (int i = 0; i < 20; i++) wr(8'(8'h80 + i));
    for (int i = 0; i < 20; i++) rd();
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < DEPTH; i++) rd();

    // Concurrent traffic at occupancy 10.
    for (int i = 0; i < 10; i++) wr(8'(8'hC0 + i));
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 10; i++) rd();

    // Both enables at empty, then at full.
    cyc(1'b1, 1'b1, 1'b1, 8'h3C);
    rd();
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) rd();

    // Mid-operation reset with 12 words stored.
    for (int i = 0; i < 12; i++) wr(8'(8'h10 + i));
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    wr(8'hA5);
    rd();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // Random traffic with rare resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    for (int i = 0; i <= DEPTH; i++) rd();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
